cci_mpf_sim_mem_responder: RTL

- Simulation/emulation endpoint that sits on the QLP side of a CCI MPF request path and answers requests as the platform would.
- Accepts channel-0 read requests and channel-1 write requests, backed by a local line-addressed memory.
- Returns read data on c0 Rx and write acks on c1 Rx, echoing the full Mdata unmodified. Mdata routing bits set by upstream muxes therefore round-trip intact.
- Applies almost-full backpressure on c0 Tx and lets the bench stall read service to exercise it.

---
 rtl/cci_mpf_sim_mem_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cci_mpf_sim_mem_responder.sv
// Simulated CCI MPF memory endpoint: serves c0 reads from a line-addressed
// memory through a request FIFO and acks c1 writes, echoing Mdata unmodified.
module cci_mpf_sim_mem_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 512,
  parameter int MDATA_WIDTH   = 16,
  parameter int REQ_DEPTH     = 16,
  parameter int ALMFULL_SLACK = 4,
  parameter int RD_LATENCY    = 4,
  parameter int WR_LATENCY    = 2,
  parameter bit OVF_ERROR_EN  = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           c0_tx_rd_valid,
  input  logic [ADDR_WIDTH-1:0]          c0_tx_addr,
  input  logic [MDATA_WIDTH-1:0]         c0_tx_mdata,
  output logic                           c0_tx_alm_full,
  input  logic                           c1_tx_wr_valid,
  input  logic [ADDR_WIDTH-1:0]          c1_tx_addr,
  input  logic [MDATA_WIDTH-1:0]         c1_tx_mdata,
  input  logic [DATA_WIDTH-1:0]          c1_tx_data,
  output logic                           c1_tx_alm_full,
  input  logic                           rd_throttle,
  output logic                           c0_rx_rd_valid,
  output logic [MDATA_WIDTH-1:0]         c0_rx_mdata,
  output logic [DATA_WIDTH-1:0]          c0_rx_data,
  output logic                           c1_rx_wr_valid,
  output logic [MDATA_WIDTH-1:0]         c1_rx_mdata,
  output logic [$clog2(REQ_DEPTH+1)-1:0] rd_occupancy,
  output logic                           err_overflow
);
  localparam int OCC_W = $clog2(REQ_DEPTH+1);
  localparam int PTR_W = $clog2(REQ_DEPTH);

  logic [DATA_WIDTH-1:0]  mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]  fifo_addr [REQ_DEPTH];
  logic [MDATA_WIDTH-1:0] fifo_md [REQ_DEPTH];
  logic [PTR_W-1:0]       wptr, rptr;
  logic [OCC_W-1:0]       count, count_nxt;
  logic                   alm_q, err_q, deq, enq, ovf, wr;

  logic [RD_LATENCY:1]                  rd_vld_pipe;
  logic [RD_LATENCY:1][MDATA_WIDTH-1:0] rd_md_pipe;
  logic [RD_LATENCY:1][DATA_WIDTH-1:0]  rd_data_pipe;
  logic [WR_LATENCY:1]                  wr_vld_pipe;
  logic [WR_LATENCY:1][MDATA_WIDTH-1:0] wr_md_pipe;

  assign wr  = reset_n & c1_tx_wr_valid;
  assign deq = reset_n & (count != '0) & ~rd_throttle;
  // A full FIFO still takes a request when the head leaves in the same cycle.
  assign ovf = reset_n & c0_tx_rd_valid & (count == OCC_W'(REQ_DEPTH)) & ~deq;
  assign enq = reset_n & c0_tx_rd_valid & ~ovf;

  always_comb begin
    count_nxt = count;
    case ({enq, deq})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Memory is never cleared; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr) mem[c1_tx_addr] <= c1_tx_data;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr[wptr] <= c0_tx_addr;
      fifo_md[wptr]   <= c0_tx_mdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      alm_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wptr  <= wptr + PTR_W'(enq);
      rptr  <= rptr + PTR_W'(deq);
      count <= count_nxt;
      alm_q <= count_nxt >= OCC_W'(REQ_DEPTH - ALMFULL_SLACK);
      err_q <= err_q | ovf;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (OVF_ERROR_EN && ovf) $error("read request dropped: FIFO full");
  end
`endif

  // Memory is sampled in the dequeue cycle, so writes from that same cycle are not seen.
  always_ff @(posedge clk) begin
    rd_md_pipe[1]   <= fifo_md[rptr];
    rd_data_pipe[1] <= mem[fifo_addr[rptr]];
    for (int i = 2; i <= RD_LATENCY; i++) begin
      rd_md_pipe[i]   <= rd_md_pipe[i-1];
      rd_data_pipe[i] <= rd_data_pipe[i-1];
    end
    wr_md_pipe[1] <= c1_tx_mdata;
    for (int i = 2; i <= WR_LATENCY; i++) wr_md_pipe[i] <= wr_md_pipe[i-1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_vld_pipe <= '0;
      wr_vld_pipe <= '0;
    end else begin
      rd_vld_pipe[1] <= deq;
      for (int i = 2; i <= RD_LATENCY; i++) rd_vld_pipe[i] <= rd_vld_pipe[i-1];
      wr_vld_pipe[1] <= wr;
      for (int i = 2; i <= WR_LATENCY; i++) wr_vld_pipe[i] <= wr_vld_pipe[i-1];
    end
  end

  // Outputs are forced to their reset values during any cycle with reset_n low.
  assign c0_rx_rd_valid = reset_n & rd_vld_pipe[RD_LATENCY];
  assign c0_rx_mdata    = rd_md_pipe[RD_LATENCY];
  assign c0_rx_data     = rd_data_pipe[RD_LATENCY];
  assign c1_rx_wr_valid = reset_n & wr_vld_pipe[WR_LATENCY];
  assign c1_rx_mdata    = wr_md_pipe[WR_LATENCY];
  assign rd_occupancy   = reset_n ? count : '0;
  assign err_overflow   = reset_n & err_q;
  assign c0_tx_alm_full = ~reset_n | alm_q;
  assign c1_tx_alm_full = ~reset_n;
endmodule
